// File: rtl/uart_echo_pkg.sv
// Shared types and constants for the UART echo engine.
package uart_echo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    GUARD = 2'd2
  } tx_state_e;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a separate fill counter and first-word fall-through read port.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              do_push, do_pop;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/uart_echo_fifo.sv
// Echo engine: buffers words from uart_rx and replays them in order to uart_tx.
// Define UART_ECHO_CRLF_EN to append LF after every transmitted CR.
module uart_echo_fifo
  import uart_echo_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data,
  output logic [CNT_W-1:0]  fifo_count,
  output logic              overflow,
  input  logic              clr_ovf
);

  tx_state_e         state_q, state_d;
  logic              tx_start_q, tx_start_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              overflow_q, overflow_d;
  logic              pop_c;
  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_head;
`ifdef UART_ECHO_CRLF_EN
  logic              lf_pend_q, lf_pend_d;
`endif

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_ready),
    .push_data (rx_data),
    .pop       (pop_c),
    .pop_data  (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Transmit sequencing; a pending LF takes priority over the FIFO head.
  always_comb begin
    state_d    = state_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    pop_c      = 1'b0;
`ifdef UART_ECHO_CRLF_EN
    lf_pend_d  = lf_pend_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef UART_ECHO_CRLF_EN
        if (!tx_busy && lf_pend_q) begin
          tx_data_d  = DATA_W'(ASCII_LF);
          tx_start_d = 1'b1;
          lf_pend_d  = 1'b0;
          state_d    = START;
        end else
`endif
        if (!tx_busy && !fifo_empty) begin
          pop_c      = 1'b1;
          tx_data_d  = fifo_head;
          tx_start_d = 1'b1;
          state_d    = START;
`ifdef UART_ECHO_CRLF_EN
          lf_pend_d  = (fifo_head[7:0] == ASCII_CR);
`endif
        end
      end
      START:   state_d = GUARD;
      GUARD:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sticky drop flag; a new drop in the clearing cycle keeps it set.
  always_comb begin
    overflow_d = overflow_q;
    if (clr_ovf) overflow_d = 1'b0;
    if (rx_ready && fifo_full && !pop_c) overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      overflow_q <= 1'b0;
`ifdef UART_ECHO_CRLF_EN
      lf_pend_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      overflow_q <= overflow_d;
`ifdef UART_ECHO_CRLF_EN
      lf_pend_q  <= lf_pend_d;
`endif
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign overflow = overflow_q;

endmodule
